// File: rtl/hp_pkg.sv
// Shared MMR bus widths, device indices and arbiter types.
package hp_pkg;

  localparam int unsigned MMR_ADDR_W     = 16;
  localparam int unsigned MMR_DATA_W     = 32;
  localparam int unsigned MMR_DEV_ADDR_W = 10;
  localparam int unsigned MMR_BASE_W     = MMR_ADDR_W - MMR_DEV_ADDR_W;
  localparam int unsigned MMR_DEV_COUNT  = 17;

  // Device indices decoded from the base field
  localparam int unsigned MMR_DEV_SYS  = 0;
  localparam int unsigned MMR_DEV_SCC  = 1;
  localparam int unsigned MMR_DEV_IC   = 2;
  localparam int unsigned MMR_DEV_EVR  = 3;
  localparam int unsigned MMR_DEV_LOAD = 16;

  localparam int unsigned MMR_TIMEOUT_DEF = 255;
  localparam logic [MMR_DATA_W-1:0] MMR_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                  wr;
    logic [MMR_ADDR_W-1:0] addr;
    logic [MMR_DATA_W-1:0] wdata;
  } mmr_req_t;

  typedef enum logic [1:0] {
    MMR_IDLE,
    MMR_ACCESS,
    MMR_RESP
  } mmr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one above the last-granted index.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             update,
  input  logic [IDX_W-1:0] update_idx,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             valid_c
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;

  // Pointer resets to N-1 so index 0 has top priority after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (update) begin
      ptr <= update_idx;
    end
  end

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N);
      if (!valid_c && req[idx]) begin
        valid_c      = 1'b1;
        grant_idx_c  = idx;
        grant_c[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmr_arbiter.sv
// MMR bus arbiter: round-robin master grant, base decode to one-hot device
// select, ack wait with timeout, and read-data/error return to the master.
module mmr_arbiter
  import hp_pkg::*;
#(
  parameter int unsigned N_MST   = 2,
  parameter int unsigned TIMEOUT = MMR_TIMEOUT_DEF,
  parameter logic [MMR_DATA_W-1:0] ERR_DATA = MMR_ERR_DATA
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_MST-1:0]                          m_req,
  input  logic [N_MST-1:0]                          m_wr,
  input  logic [N_MST-1:0][MMR_ADDR_W-1:0]          m_addr,
  input  logic [N_MST-1:0][MMR_DATA_W-1:0]          m_wdata,
  output logic [N_MST-1:0]                          m_ack,
  output logic                                      m_err,
  output logic [MMR_DATA_W-1:0]                     m_rdata,
  output logic [MMR_DEV_COUNT-1:0]                  d_sel,
  output logic                                      d_wr,
  output logic [MMR_DEV_ADDR_W-1:0]                 d_addr,
  output logic [MMR_DATA_W-1:0]                     d_wdata,
  input  logic [MMR_DEV_COUNT-1:0]                  d_ack,
  input  logic [MMR_DEV_COUNT-1:0][MMR_DATA_W-1:0]  d_rdata
);

  localparam int unsigned IDX_W     = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned DEV_IDX_W = $clog2(MMR_DEV_COUNT);
  localparam int unsigned CNT_W     = 16;

  mmr_state_e       state;
  mmr_req_t         req_q;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] cnt;

  logic [N_MST-1:0]      arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;
  logic [MMR_BASE_W-1:0] new_base;
  logic [DEV_IDX_W-1:0]  new_dev;
  logic [DEV_IDX_W-1:0]  dev;

  rr_arbiter #(.N(N_MST)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (m_req),
    .update      (state == MMR_RESP),
    .update_idx  (grant_idx),
    .grant_c     (arb_grant),
    .grant_idx_c (arb_idx),
    .valid_c     (arb_valid)
  );

  assign new_base = m_addr[arb_idx][MMR_ADDR_W-1:MMR_DEV_ADDR_W];
  assign new_dev  = DEV_IDX_W'(new_base);
  assign dev      = DEV_IDX_W'(req_q.addr[MMR_ADDR_W-1:MMR_DEV_ADDR_W]);

  // Device request fields come straight from the captured request register
  assign d_wr    = req_q.wr;
  assign d_addr  = req_q.addr[MMR_DEV_ADDR_W-1:0];
  assign d_wdata = req_q.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MMR_IDLE;
      req_q     <= '0;
      grant_idx <= '0;
      cnt       <= '0;
      m_ack     <= '0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      d_sel     <= '0;
    end else begin
      case (state)
        MMR_IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            req_q     <= '{wr: m_wr[arb_idx], addr: m_addr[arb_idx], wdata: m_wdata[arb_idx]};
            cnt       <= '0;
            if (new_base < MMR_BASE_W'(MMR_DEV_COUNT)) begin
              d_sel <= MMR_DEV_COUNT'(1) << new_dev;
              state <= MMR_ACCESS;
            end else begin
              m_ack   <= arb_grant;
              m_err   <= 1'b1;
              m_rdata <= ERR_DATA;
              state   <= MMR_RESP;
            end
          end
        end
        // Only the selected device's ack counts; others are ignored
        MMR_ACCESS: begin
          if (d_ack[dev]) begin
            m_ack   <= N_MST'(1) << grant_idx;
            m_err   <= 1'b0;
            m_rdata <= req_q.wr ? '0 : d_rdata[dev];
            d_sel   <= '0;
            state   <= MMR_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            m_ack   <= N_MST'(1) << grant_idx;
            m_err   <= 1'b1;
            m_rdata <= ERR_DATA;
            d_sel   <= '0;
            state   <= MMR_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MMR_RESP: begin
          m_ack   <= '0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          state   <= MMR_IDLE;
        end
        default: state <= MMR_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmr_arbiter.md
# mmr_arbiter

Shares the 32-bit memory-mapped register bus between several masters (PCIe BAR0 bridge, internal loader) and routes each access to one of `MMR_DEV_COUNT` register devices. Grants one transaction at a time with round-robin priority, decodes the base field of the address into a one-hot device select, waits for the device acknowledge under a timeout, and returns read data or an error to the granted master. Sits between the BAR0 bridge and the per-device MMR slaves (SYS, SCC, IC, EVR, …, LOAD).

## Interface
Parameters:
- `N_MST`, 2, number of masters (index 0 = PCIe bridge)
- `TIMEOUT`, 255, device-ack timeout in clk cycles (1..65535)
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on timeout or bad decode

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `m_req`  in  N_MST  transaction pending, level, held until ack
- `m_wr`  in  N_MST  1 = write, 0 = read
- `m_addr`  in  N_MST×MMR_ADDR_W  [15:10] base (device index), [9:0] device address
- `m_wdata`  in  N_MST×MMR_DATA_W  write data
- `m_ack`  out  N_MST  one-cycle completion pulse
- `m_err`  out  1  valid with `m_ack`: timeout or bad decode
- `m_rdata`  out  MMR_DATA_W  valid with `m_ack`
- `d_sel`  out  MMR_DEV_COUNT  one-hot device select, held during access
- `d_wr`, `d_addr` (MMR_DEV_ADDR_W), `d_wdata` (MMR_DATA_W)  out  shared request fields
- `d_ack`  in  MMR_DEV_COUNT  device completion, one cycle
- `d_rdata`  in  MMR_DEV_COUNT×MMR_DATA_W  device read data, valid with `d_ack`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `m_req`, the round-robin arbiter picks a master starting one above the last granted. Registers grant, `wr`, `addr`, `wdata`. Base < MMR_DEV_COUNT → ACCESS with `d_sel[base]`=1. Otherwise → RESP with `m_err`=1, `m_rdata`=ERR_DATA, and no select.
- ACCESS: `d_sel`, `d_wr`, `d_addr`, `d_wdata` are constant. The timeout counter increments every cycle.
  - `d_ack[base]`=1 → capture `d_rdata[base]` and go to RESP with `err`=0. For writes, rdata is 0.
  - Counter reaches TIMEOUT−1 without ack → RESP with `err`=1, rdata=ERR_DATA.
  - `d_ack` from a non-selected device is ignored.
- RESP: `m_ack[grant]`=1 for exactly one cycle, with `m_err`/`m_rdata`. `d_sel`=0. The last-granted pointer is updated. Next state is IDLE.
- A master deasserts `m_req` in the cycle after its `m_ack` unless it is issuing a new transaction. Request fields are ignored outside IDLE.
- Late `d_ack` arriving after timeout, in RESP or IDLE, is dropped.
- Reset, including mid-transaction: state IDLE, all outputs 0, counter 0, pointer = N_MST−1, so master 0 wins first.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: `d_sel` high.
- Device acks at cycle k≥1 → `m_ack` at cycle k+1 → IDLE at k+2.
- Minimum request-to-ack latency: 2 cycles. Minimum issue rate: one transaction per 3 cycles.
- Timeout: `d_sel` high for exactly TIMEOUT cycles, `m_ack` in the next cycle.
- Bad decode: `m_ack` at cycle 1.
- All outputs are registered. No combinational path from `m_*` or `d_*` inputs to outputs.

## Structure
- Add to `hp_pkg`: `MMR_TIMEOUT_DEF` = 255, `MMR_ERR_DATA` = 32'hDEAD_BEEF, and typedef `mmr_req_t` {wr, addr[MMR_ADDR_W], wdata[MMR_DATA_W]}. Existing `MMR_*` widths and device indices are used unchanged.
- Sub-module `rr_arbiter` (N inputs, last-grant pointer, one-hot grant). It is reusable by the BAR1/BAR2 paths.

## Test plan
- Single read: m0 reads 16'h0C04 (EVR=3, addr 4); EVR acks at cycle 3 with 32'h1234_5678 → `d_sel`=17'h00008, `d_addr`=4, `m_ack[0]` at cycle 4, rdata 32'h1234_5678, err 0.
- Contention: m0 and m1 request in the same cycle, both re-requesting continuously → grants alternate 0,1,0,1. No master is granted twice in a row while the other waits.
- Timeout: m1 writes to SCC (base 1) with no ack, TIMEOUT=8 → `d_sel[1]` high 8 cycles, then `m_ack[1]`, err 1, rdata 32'hDEAD_BEEF. A late `d_ack[1]` one cycle later produces no second ack.
- Bad decode: address 16'hFC00 (base 63) → no `d_sel`, `m_ack` at cycle 1, err 1, rdata ERR_DATA.
- Reset mid-ACCESS: assert `rst` while `d_sel[6]` high → `d_sel`, `m_ack` = 0 immediately. After release, m0 and m1 requesting together → m0 granted first.
- Stray ack: `d_ack[2]` pulses while `d_sel[5]` is active → ignored; the transaction completes only on `d_ack[5]`.
